// File: rtl/sonic_echo_if.sv
`default_nettype none
// ============================================================================
// Module   : sonic_echo_if
// Purpose  : Trig/echo bundle between sonic_top (master) and the emulator.
// Revision : 1.0  initial release
// ============================================================================
interface sonic_echo_if;
   logic       trig_i;
   logic [8:0] distance_cm_i;
   logic       echo_o;
   logic       busy_o;
   logic [7:0] trig_cnt_o;
   logic [7:0] bad_trig_cnt_o;

   modport master (
      output trig_i, distance_cm_i,
      input  echo_o, busy_o, trig_cnt_o, bad_trig_cnt_o
   );

   modport slave (
      input  trig_i, distance_cm_i,
      output echo_o, busy_o, trig_cnt_o, bad_trig_cnt_o
   );
endinterface
`default_nettype wire

// File: rtl/sonic_echo_emulator.sv
`default_nettype none
// ============================================================================
// Module   : sonic_echo_emulator
// Purpose  : HC-SR04 responder; answers a valid trig with a distance-scaled
//            echo pulse. Define SONIC_EMU_STATS_EN to build trigger counters.
// Revision : 1.0  initial release
// ============================================================================
module sonic_echo_emulator #(
   parameter int MIN_TRIG_CYC = 1000,
   parameter int BURST_CYC    = 20000,
   parameter int CYC_PER_CM   = 5800,
   parameter int MIN_CM       = 2,
   parameter int MAX_CM       = 400,
   parameter int TIMEOUT_CYC  = 3800000,
   parameter int HOLDOFF_CYC  = 6000000
) (
   input  wire           clk,
   input  wire           rst,
   sonic_echo_if.slave   bus
);

   localparam int                HI_W       = $clog2(MIN_TRIG_CYC + 1);
   localparam logic [HI_W-1:0]   HI_MAX     = HI_W'(MIN_TRIG_CYC - 1);
   localparam logic [22:0]       BURST_LAST = 23'(BURST_CYC - 1);
   localparam logic [22:0]       HOLD_LAST  = 23'(HOLDOFF_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARMED   = 3'd1,
      S_TRIG_HI = 3'd2,
      S_BURST   = 3'd3,
      S_ECHO    = 3'd4,
      S_HOLDOFF = 3'd5
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      sync_q;
   logic            trig_dly_q;
   logic [1:0]      primed_q;
   logic [HI_W-1:0] hi_cnt_q, hi_cnt_d;
   logic [22:0]     cnt_q, cnt_d;
   logic [21:0]     width_q, width_d;
   logic            echo_q, echo_d;

   logic            trig_s;
   logic            trig_rise;
   logic            trig_fall;
   logic            hi_ok;
   logic [8:0]      dist_clamped;
   logic [21:0]     width_calc;
   logic [22:0]     echo_last;

   assign trig_s    = sync_q[1];
   assign trig_rise = trig_s & ~trig_dly_q;
   assign trig_fall = ~trig_s & trig_dly_q;
   // The rise cycle is the first high cycle, so the counter lags by one.
   assign hi_ok     = (hi_cnt_q >= HI_MAX);
   assign echo_last = {1'b0, width_q - 22'd1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q     <= 2'b00;
         trig_dly_q <= 1'b0;
         primed_q   <= 2'b00;
      end else begin
         sync_q     <= {sync_q[0], bus.trig_i};
         trig_dly_q <= trig_s;
         primed_q   <= {primed_q[0], 1'b1};
      end
   end

   always_comb begin
      dist_clamped = bus.distance_cm_i;
      width_calc   = 22'(TIMEOUT_CYC);
      if (bus.distance_cm_i <= 9'(MAX_CM)) begin
         if (bus.distance_cm_i < 9'(MIN_CM)) begin
            dist_clamped = 9'(MIN_CM);
         end
         width_calc = 22'(dist_clamped) * 22'(CYC_PER_CM);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         hi_cnt_q <= '0;
         cnt_q    <= '0;
         width_q  <= '0;
         echo_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         hi_cnt_q <= hi_cnt_d;
         cnt_q    <= cnt_d;
         width_q  <= width_d;
         echo_q   <= echo_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      hi_cnt_d = hi_cnt_q;
      cnt_d    = cnt_q;
      width_d  = width_q;
      case (state_q)
         // Waiting for a settled low trig keeps a trig held through reset out.
         S_IDLE: begin
            if (primed_q[1] && !trig_s) begin
               state_d = S_ARMED;
            end
         end
         S_ARMED: begin
            if (trig_rise) begin
               state_d  = S_TRIG_HI;
               hi_cnt_d = '0;
            end
         end
         S_TRIG_HI: begin
            if (trig_fall) begin
               if (hi_ok) begin
                  state_d = S_BURST;
                  cnt_d   = '0;
                  width_d = width_calc;
               end else begin
                  state_d = S_ARMED;
               end
            end else if (hi_cnt_q != HI_MAX) begin
               hi_cnt_d = hi_cnt_q + 1'b1;
            end
         end
         S_BURST: begin
            if (cnt_q == BURST_LAST) begin
               state_d = S_ECHO;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 23'd1;
            end
         end
         S_ECHO: begin
            if (cnt_q == echo_last) begin
               state_d = S_HOLDOFF;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 23'd1;
            end
         end
         S_HOLDOFF: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 23'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Registered from the next state so echo tracks the ECHO state exactly.
   assign echo_d     = (state_d == S_ECHO);
   assign bus.echo_o = echo_q;
   assign bus.busy_o = (state_q == S_TRIG_HI) || (state_q == S_BURST) ||
                       (state_q == S_ECHO)    || (state_q == S_HOLDOFF);

`ifdef SONIC_EMU_STATS_EN
   logic [7:0] trig_cnt_q;
   logic [7:0] bad_cnt_q;
   logic       accept_evt;
   logic       bad_evt;

   assign accept_evt = (state_q == S_TRIG_HI) && trig_fall && hi_ok;
   assign bad_evt    = ((state_q == S_TRIG_HI) && trig_fall && !hi_ok) ||
                       (trig_rise && ((state_q == S_BURST) ||
                                      (state_q == S_ECHO)  ||
                                      (state_q == S_HOLDOFF)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trig_cnt_q <= 8'd0;
         bad_cnt_q  <= 8'd0;
      end else begin
         if (accept_evt) begin
            trig_cnt_q <= trig_cnt_q + 8'd1;
         end
         if (bad_evt) begin
            bad_cnt_q <= bad_cnt_q + 8'd1;
         end
      end
   end

   assign bus.trig_cnt_o     = trig_cnt_q;
   assign bus.bad_trig_cnt_o = bad_cnt_q;
`else
   assign bus.trig_cnt_o     = 8'd0;
   assign bus.bad_trig_cnt_o = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sonic_echo_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sonic_echo_emulator
// Purpose  : Directed vector bench for sonic_echo_emulator with sim parameters.
// Revision : 1.0  initial release
// ============================================================================
module tb_sonic_echo_emulator;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sonic_echo_if bus ();

   sonic_echo_emulator #(
      .MIN_TRIG_CYC (10),
      .BURST_CYC    (20),
      .CYC_PER_CM   (5),
      .MIN_CM       (2),
      .MAX_CM       (400),
      .TIMEOUT_CYC  (3000),
      .HOLDOFF_CYC  (100)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef SONIC_EMU_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      int         hi;
      logic [8:0] d;
      bit         acc;
      int         lat;
      int         wid;
   } vec_t;

   vec_t       vecs [10];
   int         checks   = 0;
   int         failures = 0;
   logic [7:0] n_acc    = 8'd0;
   logic [7:0] n_bad    = 8'd0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic check_stats(input string name);
      check({name, "_trig_cnt"}, int'(bus.trig_cnt_o), STATS ? int'(n_acc) : 0);
      check({name, "_bad_cnt"}, int'(bus.bad_trig_cnt_o), STATS ? int'(n_bad) : 0);
   endtask

   task automatic pulse(input int hi, input logic [8:0] d);
      @(negedge clk);
      bus.distance_cm_i = d;
      bus.trig_i        = 1'b1;
      repeat (hi) @(negedge clk);
      bus.trig_i = 1'b0;
   endtask

   // Counts clock edges from trig fall until echo is seen high.
   task automatic wait_rise(input int chg_at, input logic [8:0] chg_d,
                            output int lat, output bit busy_bad);
      lat      = 0;
      busy_bad = 1'b0;
      while (!bus.echo_o && lat < 400) begin
         @(posedge clk);
         #1;
         lat++;
         if (!bus.busy_o) busy_bad = 1'b1;
         if (lat == chg_at) bus.distance_cm_i = chg_d;
      end
   endtask

   task automatic wait_fall(output int wid, output bit busy_bad);
      wid      = 0;
      busy_bad = 1'b0;
      while (bus.echo_o && wid < 5000) begin
         @(posedge clk);
         #1;
         wid++;
         if (!bus.busy_o) busy_bad = 1'b1;
      end
   endtask

   task automatic watch_quiet(input int n, output bit saw);
      saw = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (bus.echo_o) saw = 1'b1;
      end
   endtask

   task automatic full_echo(input string name, input int exp_wid,
                            input int chg_at, input logic [8:0] chg_d);
      int lat, wid;
      bit b1, b2;
      wait_rise(chg_at, chg_d, lat, b1);
      check({name, "_latency"}, lat, 23);
      wait_fall(wid, b2);
      check({name, "_width"}, wid, exp_wid);
      check({name, "_busy_gap"}, int'(b1 | b2), 0);
   endtask

   initial begin
      int lat, wid;
      bit saw, bb;

      vecs[0] = '{hi: 12, d: 9'd30,  acc: 1'b1, lat: 23, wid: 150};
      vecs[1] = '{hi: 8,  d: 9'd30,  acc: 1'b0, lat: 0,  wid: 0};
      vecs[2] = '{hi: 12, d: 9'd0,   acc: 1'b1, lat: 23, wid: 10};
      vecs[3] = '{hi: 12, d: 9'd401, acc: 1'b1, lat: 23, wid: 3000};
      vecs[4] = '{hi: 12, d: 9'd400, acc: 1'b1, lat: 23, wid: 2000};
      vecs[5] = '{hi: 10, d: 9'd50,  acc: 1'b1, lat: 23, wid: 250};
      vecs[6] = '{hi: 9,  d: 9'd50,  acc: 1'b0, lat: 0,  wid: 0};
      vecs[7] = '{hi: 12, d: 9'd2,   acc: 1'b1, lat: 23, wid: 10};
      vecs[8] = '{hi: 12, d: 9'd1,   acc: 1'b1, lat: 23, wid: 10};
      vecs[9] = '{hi: 20, d: 9'd511, acc: 1'b1, lat: 23, wid: 3000};

      rst               = 1'b1;
      bus.trig_i        = 1'b0;
      bus.distance_cm_i = 9'd0;
      repeat (2) @(negedge clk);
      check("reset_echo", int'(bus.echo_o), 0);
      check("reset_busy", int'(bus.busy_o), 0);
      check_stats("reset");
      rst = 1'b0;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         pulse(vecs[i].hi, vecs[i].d);
         if (vecs[i].acc) begin
            wait_rise(-1, 9'd0, lat, bb);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            wait_fall(wid, bb);
            check($sformatf("vec%0d_width", i), wid, vecs[i].wid);
            n_acc++;
            repeat (110) @(negedge clk);
         end else begin
            watch_quiet(40, saw);
            check($sformatf("vec%0d_no_echo", i), int'(saw), 0);
            check($sformatf("vec%0d_idle_busy", i), int'(bus.busy_o), 0);
            n_bad++;
         end
      end
      check_stats("table");

      // Trig during holdoff is ignored, one after holdoff is honoured.
      pulse(12, 9'd30);
      full_echo("hold_first", 150, -1, 9'd0);
      n_acc++;
      repeat (48) @(negedge clk);
      pulse(12, 9'd30);
      watch_quiet(30, saw);
      check("hold_ignored_no_echo", int'(saw), 0);
      n_bad++;
      check_stats("hold_ignored");
      repeat (20) @(negedge clk);
      pulse(12, 9'd30);
      full_echo("hold_third", 150, -1, 9'd0);
      n_acc++;
      check_stats("hold_third");
      repeat (110) @(negedge clk);

      // Distance change during burst must not alter the pulse in flight.
      pulse(12, 9'd30);
      full_echo("dist_change", 150, 8, 9'd100);
      n_acc++;
      repeat (110) @(negedge clk);
      bus.distance_cm_i = 9'd30;

      // Reset in the middle of ECHO with trig held high across release.
      pulse(12, 9'd30);
      wait_rise(-1, 9'd0, lat, bb);
      check("rst_mid_latency", lat, 23);
      repeat (40) @(posedge clk);
      @(negedge clk);
      rst        = 1'b1;
      bus.trig_i = 1'b1;
      #1;
      check("rst_mid_echo_drop", int'(bus.echo_o), 0);
      check("rst_mid_busy_drop", int'(bus.busy_o), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n_acc = 8'd0;
      n_bad = 8'd0;
      check_stats("rst_mid");
      watch_quiet(60, saw);
      check("held_trig_no_echo", int'(saw), 0);
      check("held_trig_busy", int'(bus.busy_o), 0);
      @(negedge clk);
      bus.trig_i = 1'b0;
      repeat (5) @(negedge clk);
      pulse(12, 9'd30);
      full_echo("after_rst", 150, -1, 9'd0);
      n_acc++;
      check_stats("after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
